// File: rtl/ahb_bus_arbiter.sv
// AHB arbiter and master mux: priority/round-robin grant with lock and quantum,
// separate address-phase and data-phase owners, responses broadcast to all masters.
module ahb_bus_arbiter #(
  parameter int NUM_MST  = 2,
  parameter int PARK_MST = 0,
  parameter int QUANTUM  = 8,
  parameter int HADDR_W  = 32,
  parameter int HDATA_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_MST-1:0]           mst_hbusreq_i,
  input  logic [NUM_MST-1:0]           mst_priority_i,
  input  logic [2*NUM_MST-1:0]         mst_htrans_i,
  input  logic [NUM_MST-1:0]           mst_hsel_i,
  input  logic [NUM_MST-1:0]           mst_hwrite_i,
  input  logic [NUM_MST-1:0]           mst_hmastlock_i,
  input  logic [HADDR_W*NUM_MST-1:0]   mst_haddr_i,
  input  logic [HDATA_W*NUM_MST-1:0]   mst_hwdata_i,
  input  logic [3*NUM_MST-1:0]         mst_hsize_i,
  input  logic [3*NUM_MST-1:0]         mst_hburst_i,
  input  logic [4*NUM_MST-1:0]         mst_hprot_i,
  output logic [NUM_MST-1:0]           mst_hgrant_o,
  output logic                         mst_hready_o,
  output logic                         mst_hresp_o,
  output logic [HDATA_W-1:0]           mst_hrdata_o,
  output logic                         s_hsel_o,
  output logic [1:0]                   s_htrans_o,
  output logic [HADDR_W-1:0]           s_haddr_o,
  output logic                         s_hwrite_o,
  output logic [2:0]                   s_hsize_o,
  output logic [2:0]                   s_hburst_o,
  output logic [3:0]                   s_hprot_o,
  output logic                         s_hmastlock_o,
  output logic [HDATA_W-1:0]           s_hwdata_o,
  input  logic                         s_hready_i,
  input  logic                         s_hresp_i,
  input  logic [HDATA_W-1:0]           s_hrdata_i,
  output logic [1:0]                   hmaster_o,
  output logic [1:0]                   hmaster_data_o
);

  localparam logic [1:0]         PARK_IDX = 2'(PARK_MST);
  localparam logic [7:0]         QMAX     = 8'(QUANTUM);
  localparam logic [NUM_MST-1:0] PARK_OH  = {{(NUM_MST-1){1'b0}}, 1'b1} << PARK_MST;

  logic [NUM_MST-1:0] grant_q, grant_d;
  logic [1:0]         hmaster_q, hmaster_d;
  logic [1:0]         hmaster_data_q, hmaster_data_d;
  logic [7:0]         qcnt_q, qcnt_d;

  logic [1:0]         gnt_idx, sel_idx, hi_idx, lo_idx;
  logic               hi_found, lo_found;
  logic [NUM_MST-1:0] hm_oh, base, hp, cand;
  logic [1:0]         hm_trans;
  logic               hm_lock, locked, others, q_expired;

  always_comb begin
    gnt_idx  = PARK_IDX;
    hm_oh    = '0;
    hm_trans = 2'b00;
    hm_lock  = 1'b0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (grant_q[i]) gnt_idx = 2'(i);
      if (hmaster_q == 2'(i)) begin
        hm_oh[i] = 1'b1;
        hm_trans = mst_htrans_i[2*i +: 2];
        hm_lock  = mst_hmastlock_i[i];
      end
    end
  end

  // Quantum exclusion is applied before the high-priority restriction.
  assign locked    = hm_lock && (hm_trans != 2'b00);
  assign others    = |(mst_hbusreq_i & ~hm_oh);
  assign q_expired = (qcnt_q == QMAX) && others;
  assign base      = q_expired ? (mst_hbusreq_i & ~hm_oh) : mst_hbusreq_i;
  assign hp        = base & mst_priority_i;
  assign cand      = (|hp) ? hp : base;

  // Round-robin: lowest candidate above hmaster, else lowest candidate overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = 2'd0;
    lo_found = 1'b0;
    lo_idx   = 2'd0;
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      if (cand[i]) begin
        lo_found = 1'b1;
        lo_idx   = 2'(i);
        if (2'(i) > hmaster_q) begin
          hi_found = 1'b1;
          hi_idx   = 2'(i);
        end
      end
    end
  end

  always_comb begin
    grant_d = '0;
    if (locked)        sel_idx = hmaster_q;
    else if (hi_found) sel_idx = hi_idx;
    else if (lo_found) sel_idx = lo_idx;
    else               sel_idx = PARK_IDX;
    for (int i = 0; i < NUM_MST; i++) grant_d[i] = (sel_idx == 2'(i));
  end

  always_comb begin
    hmaster_d      = hmaster_q;
    hmaster_data_d = hmaster_data_q;
    qcnt_d         = qcnt_q;
    if (s_hready_i) begin
      hmaster_d      = gnt_idx;
      hmaster_data_d = hmaster_q;
      if (gnt_idx != hmaster_q)               qcnt_d = 8'd0;
      else if (hm_trans[1] && qcnt_q != QMAX) qcnt_d = qcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q        <= PARK_OH;
      hmaster_q      <= PARK_IDX;
      hmaster_data_q <= PARK_IDX;
      qcnt_q         <= 8'd0;
    end else begin
      grant_q        <= grant_d;
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_data_d;
      qcnt_q         <= qcnt_d;
    end
  end

  always_comb begin
    s_hsel_o      = mst_hsel_i[0];
    s_htrans_o    = mst_htrans_i[1:0];
    s_haddr_o     = mst_haddr_i[HADDR_W-1:0];
    s_hwrite_o    = mst_hwrite_i[0];
    s_hsize_o     = mst_hsize_i[2:0];
    s_hburst_o    = mst_hburst_i[2:0];
    s_hprot_o     = mst_hprot_i[3:0];
    s_hmastlock_o = mst_hmastlock_i[0];
    s_hwdata_o    = mst_hwdata_i[HDATA_W-1:0];
    for (int i = 0; i < NUM_MST; i++) begin
      if (hmaster_q == 2'(i)) begin
        s_hsel_o      = mst_hsel_i[i];
        s_htrans_o    = mst_htrans_i[2*i +: 2];
        s_haddr_o     = mst_haddr_i[HADDR_W*i +: HADDR_W];
        s_hwrite_o    = mst_hwrite_i[i];
        s_hsize_o     = mst_hsize_i[3*i +: 3];
        s_hburst_o    = mst_hburst_i[3*i +: 3];
        s_hprot_o     = mst_hprot_i[4*i +: 4];
        s_hmastlock_o = mst_hmastlock_i[i];
      end
      if (hmaster_data_q == 2'(i)) s_hwdata_o = mst_hwdata_i[HDATA_W*i +: HDATA_W];
    end
  end

  assign mst_hgrant_o   = grant_q;
  assign mst_hready_o   = s_hready_i;
  assign mst_hresp_o    = s_hresp_i;
  assign mst_hrdata_o   = s_hrdata_i;
  assign hmaster_o      = hmaster_q;
  assign hmaster_data_o = hmaster_data_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: directed scenarios plus random traffic, scoreboarded
// against an index-level model of the grant/ownership rules.
module tb_ahb_bus_arbiter;
  localparam int N    = 3;
  localparam int PARK = 2;
  localparam int Q    = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req, pri, hsel, hwrite, lock;
  logic [2*N-1:0]  htrans;
  logic [AW*N-1:0] haddr;
  logic [DW*N-1:0] hwdata;
  logic [3*N-1:0]  hsize, hburst;
  logic [4*N-1:0]  hprot;
  logic            hready, hresp;
  logic [DW-1:0]   hrdata;

  logic [N-1:0]    gnt_o;
  logic            m_hready_o, m_hresp_o;
  logic [DW-1:0]   m_hrdata_o;
  logic            s_hsel, s_hwrite, s_hmastlock;
  logic [1:0]      s_htrans;
  logic [AW-1:0]   s_haddr;
  logic [2:0]      s_hsize, s_hburst;
  logic [3:0]      s_hprot;
  logic [DW-1:0]   s_hwdata;
  logic [1:0]      hm_o, hmd_o;

  ahb_bus_arbiter #(.NUM_MST(N), .PARK_MST(PARK), .QUANTUM(Q), .HADDR_W(AW), .HDATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .mst_hbusreq_i(req), .mst_priority_i(pri), .mst_htrans_i(htrans), .mst_hsel_i(hsel),
    .mst_hwrite_i(hwrite), .mst_hmastlock_i(lock), .mst_haddr_i(haddr), .mst_hwdata_i(hwdata),
    .mst_hsize_i(hsize), .mst_hburst_i(hburst), .mst_hprot_i(hprot),
    .mst_hgrant_o(gnt_o), .mst_hready_o(m_hready_o), .mst_hresp_o(m_hresp_o), .mst_hrdata_o(m_hrdata_o),
    .s_hsel_o(s_hsel), .s_htrans_o(s_htrans), .s_haddr_o(s_haddr), .s_hwrite_o(s_hwrite),
    .s_hsize_o(s_hsize), .s_hburst_o(s_hburst), .s_hprot_o(s_hprot), .s_hmastlock_o(s_hmastlock),
    .s_hwdata_o(s_hwdata), .s_hready_i(hready), .s_hresp_i(hresp), .s_hrdata_i(hrdata),
    .hmaster_o(hm_o), .hmaster_data_o(hmd_o)
  );

  typedef struct {
    logic [N-1:0]  gnt;
    logic [1:0]    hm, hmd;
    logic [AW-1:0] addr;
    logic [1:0]    trans;
    logic [12:0]   ctl;
    logic [DW-1:0] wdata, rdata;
    logic [1:0]    rsp;
  } exp_t;

  exp_t sbq[$];
  int   ntot = 0;
  int   nbad = 0;
  bit   chk_on = 0;

  // Model state: grant index, address owner, data owner, accepted-transfer count.
  int m_gnt, m_hm, m_hmd, m_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    ntot++;
    if (act !== exp_v) begin
      nbad++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp_v);
    end
  endtask

  task automatic tick();
    exp_t e;
    int   hmt, ng;
    bit   lk, oth, anyp;
    bit   cand[N];
    e.gnt        = '0;
    e.gnt[m_gnt] = 1'b1;
    e.hm         = 2'(m_hm);
    e.hmd        = 2'(m_hmd);
    e.addr       = haddr[m_hm*AW +: AW];
    e.trans      = htrans[2*m_hm +: 2];
    e.ctl        = {hsel[m_hm], hwrite[m_hm], lock[m_hm], hsize[3*m_hm +: 3],
                    hburst[3*m_hm +: 3], hprot[4*m_hm +: 4]};
    e.wdata      = hwdata[m_hmd*DW +: DW];
    e.rdata      = hrdata;
    e.rsp        = {hready, hresp};
    chk_on = 1;
    sbq.push_back(e);

    if (rst) begin
      m_gnt = PARK; m_hm = PARK; m_hmd = PARK; m_cnt = 0;
    end else begin
      hmt  = int'(htrans[2*m_hm +: 2]);
      lk   = lock[m_hm] && (hmt != 0);
      oth  = 0;
      anyp = 0;
      for (int j = 0; j < N; j++) if (j != m_hm && req[j]) oth = 1;
      for (int j = 0; j < N; j++) begin
        cand[j] = req[j] && !(m_cnt == Q && oth && j == m_hm);
        if (cand[j] && pri[j]) anyp = 1;
      end
      if (anyp) for (int j = 0; j < N; j++) cand[j] = cand[j] && pri[j];
      ng = PARK;
      if (lk) ng = m_hm;
      else for (int k = N; k >= 1; k--) if (cand[(m_hm + k) % N]) ng = (m_hm + k) % N;
      if (hready) begin
        if (m_gnt != m_hm) m_cnt = 0;
        else if (hmt >= 2 && m_cnt < Q) m_cnt++;
        m_hmd = m_hm;
        m_hm  = m_gnt;
      end
      m_gnt = ng;
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      haddr[i*AW +: AW]  = $urandom;
      hwdata[i*DW +: DW] = $urandom;
    end
    hsel   = N'($urandom);
    hwrite = N'($urandom);
    hsize  = (3*N)'($urandom);
    hburst = (3*N)'($urandom);
    hprot  = (4*N)'($urandom);
    hrdata = $urandom;
    hresp  = 1'($urandom);
  endtask

  // mode 0 idle, 1 single request, 2 contention, 3 priority with stalls, 4 lock, else random
  task automatic run(input int mode, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rand_data();
      req = '0; pri = '0; lock = '0; htrans = '0; hready = 1'b1; rst = 1'b0;
      case (mode)
        0: hsel = '0;
        1: begin req = 3'b010; htrans[3:2] = 2'b10; end
        2: begin req = 3'b011; htrans[1:0] = 2'b10; htrans[3:2] = 2'b10; end
        3: begin
          req = (c < 4) ? 3'b001 : 3'b011;
          pri = (c < 4) ? 3'b000 : 3'b010;
          htrans[1:0] = 2'b10;
          hready = !(c >= 5 && c < 8);
        end
        4: begin
          req = (c < 4) ? 3'b001 : 3'b011;
          htrans[1:0] = 2'b10;
          lock[0] = (c >= 4 && c < 16);
        end
        default: begin
          req    = N'($urandom);
          for (int i = 0; i < N; i++) begin
            pri[i]  = ($urandom_range(0, 5) == 0);
            lock[i] = ($urandom_range(0, 7) == 0);
          end
          htrans = (2*N)'($urandom);
          hready = ($urandom_range(0, 3) != 0);
          rst    = ($urandom_range(0, 299) == 0);
        end
      endcase
      tick();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (chk_on) begin
        if (sbq.size() == 0) begin
          ntot++; nbad++;
          $display("FAIL sbq_empty t=%0t actual=0 entries expected=1", $time);
        end else begin
          e = sbq.pop_front();
          chk("grant",    64'(gnt_o), 64'(e.gnt));
          chk("hmaster",  64'(hm_o),  64'(e.hm));
          chk("hmaster_data", 64'(hmd_o), 64'(e.hmd));
          chk("haddr",    64'({s_htrans, s_haddr}), 64'({e.trans, e.addr}));
          chk("ctl",      64'({s_hsel, s_hwrite, s_hmastlock, s_hsize, s_hburst, s_hprot}), 64'(e.ctl));
          chk("hwdata",   64'(s_hwdata), 64'(e.wdata));
          chk("response", 64'({m_hready_o, m_hresp_o, m_hrdata_o}), 64'({e.rsp, e.rdata}));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; req = '0; pri = '0; lock = '0; htrans = '0; hready = 1'b1;
    rand_data();
    hsel = '0;
    repeat (2) @(posedge clk);
    m_gnt = PARK; m_hm = PARK; m_hmd = PARK; m_cnt = 0;
    run(0, 6);
    run(1, 6);
    run(0, 4);
    run(2, 14);
    run(3, 12);
    run(0, 4);
    run(4, 22);
    run(5, 4000);
    #3;
    chk_on = 0;
    chk("sbq_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
